// File: rtl/handshake_const_check_pkg.sv
// Shared definitions for the constant-compare handshake block.
// Holds the FIFO occupancy encoding and the FIFO depth constant.
package handshake_const_check_pkg;

   localparam int FIFO_DEPTH = 2;
   localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

endpackage

// File: rtl/handshake_const_check_fifo2.sv
// Two-entry valid/ready FIFO.
// Readiness depends only on registered occupancy, so outs_ready never reaches in_ready.
module handshake_fifo2
   import handshake_const_check_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   occ_t                 state;
   occ_t                 next_state;
   logic [WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic                 push;
   logic                 pop;

   assign in_ready  = (state != OCC_FULL) && !rst;
   assign out_valid = (state != OCC_EMPTY);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OCC_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         OCC_EMPTY: if (push) next_state = OCC_ONE;
         OCC_ONE: begin
            if (push && !pop) begin
               next_state = OCC_FULL;
            end else if (pop && !push) begin
               next_state = OCC_EMPTY;
            end
         end
         OCC_FULL:  if (pop) next_state = OCC_ONE;
         default:   next_state = OCC_EMPTY;
      endcase
   end

   // Storage is cleared on reset so the head reads 0 while rst is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/handshake_const_check.sv
// Compares each accepted token against a constant, buffers the match bit
// through a two-entry FIFO and counts mismatches with saturation.
module handshake_const_check #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(1),
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic [CNT_WIDTH-1:0]  mismatch_count
);

   logic match;
   logic in_xfer;

   assign match   = (ins == CONST_VALUE);
   assign in_xfer = ins_valid && ins_ready;

   handshake_fifo2 #(
      .WIDTH(1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_data   (match),
      .in_valid  (ins_valid),
      .in_ready  (ins_ready),
      .out_data  (outs),
      .out_valid (outs_valid),
      .out_ready (outs_ready)
   );

   // Counts at acceptance time, so downstream stalls never delay it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch_count <= '0;
      end else if (in_xfer && !match && (mismatch_count != '1)) begin
         mismatch_count <= mismatch_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_handshake_const_check.sv
// Self-checking bench: directed handshake scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_handshake_const_check;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic        outs;
   logic        outs_valid;
   logic        outs_ready;
   logic [15:0] mismatch_count;

   logic [7:0]  ins2;
   logic        ins_valid2;
   logic        ins_ready2;
   logic        outs2;
   logic        outs_valid2;
   logic        outs_ready2;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;
   bit ref_q[$];
   int ref_cnt = 0;
   int ref_pops = 0;
   int ref_pushes = 0;

   always #5 clk = ~clk;

   handshake_const_check dut (
      .clk            (clk),
      .rst            (rst),
      .ins            (ins),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .outs           (outs),
      .outs_valid     (outs_valid),
      .outs_ready     (outs_ready),
      .mismatch_count (mismatch_count)
   );

   handshake_const_check #(
      .DATA_WIDTH  (8),
      .CONST_VALUE (8'd5),
      .CNT_WIDTH   (2)
   ) dut_sat (
      .clk            (clk),
      .rst            (rst),
      .ins            (ins2),
      .ins_valid      (ins_valid2),
      .ins_ready      (ins_ready2),
      .outs           (outs2),
      .outs_valid     (outs_valid2),
      .outs_ready     (outs_ready2),
      .mismatch_count (cnt2)
   );

   // Advances one clock and updates the reference model for the main instance.
   task automatic step();
      bit pop_now;
      bit push_now;
      @(posedge clk);
      if (!rst) begin
         pop_now  = (ref_q.size() > 0) && outs_ready;
         push_now = (ref_q.size() < 2) && ins_valid;
         if (pop_now) begin
            void'(ref_q.pop_front());
            ref_pops++;
         end
         if (push_now) begin
            ref_q.push_back(ins == 32'd1);
            ref_pushes++;
            if (ins != 32'd1) ref_cnt++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ins = 32'd1; ins_valid = 1'b1; outs_ready = 1'b0;
      ins2 = 8'd0; ins_valid2 = 1'b0; outs_ready2 = 1'b1;
      repeat (3) step();
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outs_valid: got %0b want 0", outs_valid); end
      checks++; if (outs !== 1'b0) begin errors++; $display("[TB] FAIL reset_outs: got %0b want 0", outs); end
      checks++; if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ins_ready: got %0b want 0", ins_ready); end
      checks++; if (mismatch_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", mismatch_count); end
      ins_valid = 1'b0;
      rst = 1'b0;
      ref_q.delete(); ref_cnt = 0;
      #1;
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %0b want 1", ins_ready); end
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid: got %0b want 0", outs_valid); end
   endtask

   task automatic test_single();
      ins = 32'd1; ins_valid = 1'b1; outs_ready = 1'b1;
      step();
      ins_valid = 1'b0;
      checks++; if (outs_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b want 1", outs_valid); end
      checks++; if (outs !== 1'b1) begin errors++; $display("[TB] FAIL single_outs: got %0b want 1", outs); end
      checks++; if (mismatch_count !== 16'd0) begin errors++; $display("[TB] FAIL single_count: got %0d want 0", mismatch_count); end
      step();
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %0b want 0", outs_valid); end
   endtask

   task automatic test_backpressure();
      outs_ready = 1'b0; ins_valid = 1'b1; ins = 32'd1;
      step();
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one: got %0b want 1", ins_ready); end
      ins = 32'd5;
      step();
      checks++; if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full: got %0b want 0", ins_ready); end
      checks++; if (mismatch_count !== 16'd1) begin errors++; $display("[TB] FAIL bp_count: got %0d want 1", mismatch_count); end
      ins = 32'd1;
      repeat (2) begin
         step();
         checks++; if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_held_ready: got %0b want 0", ins_ready); end
         checks++; if (outs !== 1'b1 || outs_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_head_stable: got %0b/%0b want 1/1", outs, outs_valid); end
      end
      checks++; if (mismatch_count !== 16'd1) begin errors++; $display("[TB] FAIL bp_count_held: got %0d want 1", mismatch_count); end
   endtask

   task automatic test_full_pop();
      outs_ready = 1'b1;
      step();
      checks++; if (outs !== 1'b0 || outs_valid !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_head: got %0b/%0b want 0/1", outs, outs_valid); end
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_no_push: got ready %0b want 1", ins_ready); end
      outs_ready = 1'b0;
      step();
      checks++; if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_push_next: got %0b want 0", ins_ready); end
      checks++; if (outs !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_order0: got %0b want 0", outs); end
      outs_ready = 1'b1; ins_valid = 1'b0;
      step();
      checks++; if (outs !== 1'b1 || outs_valid !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_order1: got %0b/%0b want 1/1", outs, outs_valid); end
      step();
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_empty: got %0b want 0", outs_valid); end
   endtask

   task automatic test_simul_one();
      outs_ready = 1'b0; ins = 32'd1; ins_valid = 1'b1;
      step();
      outs_ready = 1'b1; ins = 32'd7;
      step();
      ins_valid = 1'b0;
      checks++; if (outs !== 1'b0 || outs_valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_head: got %0b/%0b want 0/1", outs, outs_valid); end
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("[TB] FAIL simul_ready: got %0b want 1", ins_ready); end
      checks++; if (mismatch_count !== 16'd2) begin errors++; $display("[TB] FAIL simul_count: got %0d want 2", mismatch_count); end
      step();
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_drained: got %0b want 0", outs_valid); end
   endtask

   task automatic test_mid_reset();
      outs_ready = 1'b0; ins_valid = 1'b1; ins = 32'd3;
      step();
      ins = 32'd1;
      step();
      ins_valid = 1'b0;
      checks++; if (mismatch_count !== 16'd3) begin errors++; $display("[TB] FAIL midrst_pre_count: got %0d want 3", mismatch_count); end
      rst = 1'b1;
      #1;
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %0b want 0", outs_valid); end
      checks++; if (mismatch_count !== 16'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 0", mismatch_count); end
      checks++; if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %0b want 0", ins_ready); end
      outs_ready = 1'b1;
      step();
      rst = 1'b0;
      ref_q.delete(); ref_cnt = 0;
      #1;
      checks++; if (ins_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_release_ready: got %0b want 1", ins_ready); end
      step();
      checks++; if (outs_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale: got %0b want 0", outs_valid); end
   endtask

   task automatic test_saturation();
      int sat_exp[5] = '{1, 2, 3, 3, 3};
      outs_ready2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ins2 = 8'($urandom_range(0, 255));
         if (ins2 == 8'd5) ins2 = 8'd6;
         ins_valid2 = 1'b1;
         step();
         checks++; if (cnt2 !== 2'(sat_exp[i])) begin errors++; $display("[TB] FAIL sat_count%0d: got %0d want %0d", i, cnt2, sat_exp[i]); end
         checks++; if (outs2 !== 1'b0 || outs_valid2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_outs%0d: got %0b/%0b want 0/1", i, outs2, outs_valid2); end
      end
      ins2 = 8'd5;
      step();
      ins_valid2 = 1'b0;
      checks++; if (outs2 !== 1'b1 || cnt2 !== 2'd3) begin errors++; $display("[TB] FAIL sat_match: got %0b/%0d want 1/3", outs2, cnt2); end
      step();
   endtask

   task automatic test_random();
      int cycles = 0;
      int start_pushes;
      int start_pops;
      logic [15:0] exp_cnt;
      start_pushes = ref_pushes;
      start_pops   = ref_pops;
      while ((ref_pushes - start_pushes < 10000 || ref_q.size() > 0) && cycles < 60000) begin
         ins_valid  = (ref_pushes - start_pushes < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
         ins        = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
         outs_ready = 1'($urandom_range(0, 1));
         step();
         cycles++;
         exp_cnt = (ref_cnt > 65535) ? 16'hFFFF : 16'(ref_cnt);
         checks++; if (outs_valid !== (ref_q.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %0b want %0b", cycles, outs_valid, ref_q.size() > 0); end
         if (ref_q.size() > 0) begin
            checks++; if (outs !== ref_q[0]) begin errors++; $display("[TB] FAIL rand_outs@%0d: got %0b want %0b", cycles, outs, ref_q[0]); end
         end
         checks++; if (ins_ready !== (ref_q.size() < 2)) begin errors++; $display("[TB] FAIL rand_ready@%0d: got %0b want %0b", cycles, ins_ready, ref_q.size() < 2); end
         checks++; if (mismatch_count !== exp_cnt) begin errors++; $display("[TB] FAIL rand_count@%0d: got %0d want %0d", cycles, mismatch_count, exp_cnt); end
      end
      ins_valid = 1'b0;
      checks++; if (cycles >= 60000) begin errors++; $display("[TB] FAIL rand_timeout: got %0d cycles want < 60000", cycles); end
      checks++; if (ref_pops - start_pops !== 10000) begin errors++; $display("[TB] FAIL rand_tokens_out: got %0d want 10000", ref_pops - start_pops); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full_pop();
      test_simul_one();
      test_mid_reset();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
